llr_load_sequencer: RTL and testbench
=====================================

LLR_LOAD_SEQUENCER -- requirements
Module: llr_load_sequencer

Interface
REQ-001 The block SHALL have parameter LANE_BITS, default 200, giving the serial shift cycles per frame on every input lane.
REQ-002 The block SHALL have parameter DCMAX, default 200, giving the decoding-cycle limit.
REQ-003 The block SHALL have parameter FCW, default 16, giving the frame counter width.
REQ-004 The block SHALL have port Clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port Go, input, 1 bit: level request to process frames.
REQ-007 The block SHALL have port Abort, input, 1 bit: abandon the current frame.
REQ-008 The block SHALL have port EarlyStop, input, 1 bit: decoder convergence flag.
REQ-009 The block SHALL have port ShiftEn, output, 1 bit: enables the LLR lane shift registers.
REQ-010 The block SHALL have port Start, output, 1 bit: one-cycle decode-start pulse.
REQ-011 The block SHALL have ports Enable_Odd and Enable_Even, output, 1 bit each: alternate-half decoder enables.
REQ-012 The block SHALL have port Ready, output, 1 bit: one-cycle frame-complete pulse.
REQ-013 The block SHALL have port MaxHit, output, 1 bit: the last frame hit DCMAX.
REQ-014 The block SHALL have port DC, output, $clog2(DCMAX+1) bits: the live decoding-cycle count.
REQ-015 The block SHALL have port DCLast, output, same width as DC: the count latched at frame end.
REQ-016 The block SHALL have port FrameCount, output, FCW bits: the number of completed frames.

Function
REQ-017 The block SHALL use states IDLE, LOAD, START, DECODE and DONE, held in one registered state variable.
REQ-018 IDLE SHALL move to LOAD on the first edge where Go=1, and otherwise hold.
REQ-019 In LOAD, ShiftEn SHALL be 1 for exactly LANE_BITS consecutive cycles, counted 0..LANE_BITS-1 by a bit counter, and 0 in every other state.
REQ-020 When the bit counter reaches LANE_BITS-1, the next state SHALL be START, and the bit counter SHALL clear.
REQ-021 In START, Start SHALL be 1 for exactly one cycle, DC SHALL clear to 0, and the next state SHALL be DECODE.
REQ-022 In DECODE, DC SHALL increment by 1 each cycle, beginning at 1 in the first DECODE cycle.
REQ-023 In DECODE, Enable_Odd SHALL be 1 when DC is odd and Enable_Even SHALL be 1 when DC is even; the two are never high together, and both are 0 outside DECODE.
REQ-024 DECODE SHALL exit to DONE when EarlyStop=1, with MaxHit set to 0 in DONE.
REQ-025 DECODE SHALL exit to DONE when DC equals DCMAX-1 and EarlyStop=0, with MaxHit set to 1 in DONE.
REQ-026 When EarlyStop=1 on the same cycle that DC equals DCMAX-1, early stop SHALL win and MaxHit SHALL be 0.
REQ-027 In DONE, Ready SHALL be 1 for one cycle, DCLast SHALL take the final DC, and FrameCount SHALL increment, wrapping from 2^FCW-1 to 0.
REQ-028 MaxHit and DCLast SHALL hold their values until the next DONE.
REQ-029 From DONE, the next state SHALL be LOAD if Go=1 and IDLE otherwise, so back-to-back frames run with no IDLE gap.
REQ-030 Go falling during LOAD, START or DECODE SHALL be ignored, and the current frame SHALL complete.
REQ-031 Abort=1 in any non-IDLE state SHALL force IDLE on the next edge, clear the bit counter and DC, and produce no Ready, with FrameCount, DCLast and MaxHit unchanged.
REQ-032 Abort SHALL take priority over all other transitions, including DONE.
REQ-033 EarlyStop SHALL be ignored outside DECODE.

Reset
REQ-034 While Reset=1, the state SHALL be IDLE and every output and counter SHALL be 0, asynchronously.
REQ-035 Reset asserted mid-frame SHALL abandon the frame, and the first frame after reset release SHALL start with a full LANE_BITS LOAD.

Structure
REQ-036 The state enum (IDLE, LOAD, START, DECODE, DONE) and the default constants LANE_BITS_DEF=200 and DCMAX_DEF=200 SHALL live in the shared FPTD package.
REQ-037 The one sub-module SHALL be up_counter: a parameterised width, synchronous clear, enable and terminal-count flag, instantiated for the bit counter and for DC.

Verification
REQ-038 Go=1 held, EarlyStop=0 -> ShiftEn high for 200 cycles, Start for 1 cycle, DC counts 1..199, Ready with MaxHit=1 and DCLast=199, then LOAD on the next cycle.
REQ-039 EarlyStop=1 at DC=37 -> DONE next cycle, DCLast=37, MaxHit=0, FrameCount +1.
REQ-040 EarlyStop=1 exactly at DC=199 -> MaxHit=0, DCLast=199.
REQ-041 Abort=1 at LOAD bit 120 -> IDLE, no Ready, FrameCount unchanged; re-Go gives a full 200-cycle LOAD.
REQ-042 Reset pulse mid-DECODE at DC=50 -> all outputs 0 immediately; after release with Go=1, a normal frame with FrameCount ending at 1.
REQ-043 FCW=2 with five early-stopped frames -> FrameCount sequence 1, 2, 3, 0, 1, and Enable_Odd/Enable_Even never both high.

Source files
------------

// File: rtl/llr_load_sequencer_pkg.sv
// Shared FPTD definitions: sequencer state encoding and default frame geometry.
package llr_load_sequencer_pkg;

  localparam int LANE_BITS_DEF = 200;
  localparam int DCMAX_DEF     = 200;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DECODE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/llr_load_sequencer_counter.sv
// Generic up counter with synchronous clear (clear wins over enable) and a
// flag raised while the count sits at a chosen terminal value.
module up_counter #(
  parameter int WIDTH    = 8,
  parameter int TERMINAL = 255
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             at_terminal
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count       = count_reg;
  assign at_terminal = (count_reg == WIDTH'(TERMINAL));

endmodule

// File: rtl/llr_load_sequencer.sv
// Frame sequencer for the LLR decoder: shifts a frame in, pulses Start,
// runs the decode-cycle count until early stop or DCMAX, then reports.
module llr_load_sequencer
  import llr_load_sequencer_pkg::*;
#(
  parameter int LANE_BITS = LANE_BITS_DEF,
  parameter int DCMAX     = DCMAX_DEF,
  parameter int FCW       = 16
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Go,
  input  logic                         Abort,
  input  logic                         EarlyStop,
  output logic                         ShiftEn,
  output logic                         Start,
  output logic                         Enable_Odd,
  output logic                         Enable_Even,
  output logic                         Ready,
  output logic                         MaxHit,
  output logic [$clog2(DCMAX+1)-1:0]   DC,
  output logic [$clog2(DCMAX+1)-1:0]   DCLast,
  output logic [FCW-1:0]               FrameCount
);

  localparam int DCW = $clog2(DCMAX + 1);
  localparam int BCW = $clog2(LANE_BITS + 1);

  seq_state_t     state_reg, state_next;
  logic           abort_hit;
  logic           bit_tc;
  logic           dc_tc;
  logic [BCW-1:0] unused_bit_count;
  logic [DCW-1:0] dc;

  logic           shift_en_reg, start_reg, ready_reg;
  logic           odd_reg, even_reg, max_hit_reg;
  logic [DCW-1:0] dc_last_reg;
  logic [FCW-1:0] frame_count_reg;

  assign abort_hit = Abort && (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    if (abort_hit) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (Go) state_next = LOAD;
        LOAD:    if (bit_tc) state_next = START;
        START:   state_next = DECODE;
        DECODE:  if (EarlyStop || dc_tc) state_next = DONE;
        DONE:    state_next = Go ? LOAD : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Bit counter sits at 0 outside LOAD so every LOAD begins at bit 0.
  up_counter #(
    .WIDTH    (BCW),
    .TERMINAL (LANE_BITS - 1)
  ) u_bit_counter (
    .Clock       (Clock),
    .Reset       (Reset),
    .clr         (abort_hit || (state_reg != LOAD) || bit_tc),
    .en          (state_reg == LOAD),
    .count       (unused_bit_count),
    .at_terminal (bit_tc)
  );

  up_counter #(
    .WIDTH    (DCW),
    .TERMINAL (DCMAX - 1)
  ) u_dc_counter (
    .Clock       (Clock),
    .Reset       (Reset),
    .clr         (abort_hit || (state_next == START)),
    .en          (state_next == DECODE),
    .count       (dc),
    .at_terminal (dc_tc)
  );

  // Strobes are registered from the next state; the decode-half enables use
  // the parity DC will have once it has stepped on the same edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg       <= IDLE;
      shift_en_reg    <= 1'b0;
      start_reg       <= 1'b0;
      ready_reg       <= 1'b0;
      odd_reg         <= 1'b0;
      even_reg        <= 1'b0;
      max_hit_reg     <= 1'b0;
      dc_last_reg     <= '0;
      frame_count_reg <= '0;
    end else begin
      state_reg    <= state_next;
      shift_en_reg <= (state_next == LOAD);
      start_reg    <= (state_next == START);
      ready_reg    <= (state_next == DONE);
      odd_reg      <= (state_next == DECODE) && !dc[0];
      even_reg     <= (state_next == DECODE) && dc[0];
      if (state_next == DONE) begin
        max_hit_reg     <= !EarlyStop;
        dc_last_reg     <= dc;
        frame_count_reg <= frame_count_reg + FCW'(1);
      end
    end
  end

  assign ShiftEn     = shift_en_reg;
  assign Start       = start_reg;
  assign Ready       = ready_reg;
  assign Enable_Odd  = odd_reg;
  assign Enable_Even = even_reg;
  assign MaxHit      = max_hit_reg;
  assign DC          = dc;
  assign DCLast      = dc_last_reg;
  assign FrameCount  = frame_count_reg;

endmodule

// File: tb/tb_llr_load_sequencer.sv
// Randomised and directed bench for llr_load_sequencer against a frame-position model.
module tb_llr_load_sequencer;

  localparam int LB   = 200;
  localparam int DMAX = 200;
  localparam int FCW  = 2;
  localparam int DCW  = $clog2(DMAX + 1);
  localparam int FMOD = 1 << FCW;

  logic           Clock = 1'b0;
  logic           Reset = 1'b1;
  logic           Go = 1'b0, Abort = 1'b0, EarlyStop = 1'b0;
  logic           ShiftEn, Start, Enable_Odd, Enable_Even, Ready, MaxHit;
  logic [DCW-1:0] DC, DCLast;
  logic [FCW-1:0] FrameCount;

  int checks = 0;
  int errors = 0;

  // Model: position within the current frame, counted from its first LOAD cycle.
  bit m_frame = 0, m_done = 0;
  bit m_shift = 0, m_start = 0, m_odd = 0, m_even = 0, m_ready = 0, m_maxhit = 0;
  int m_pos = 0, m_dc = 0, m_last = 0, m_frames = 0;
  int es_rate = 2;

  llr_load_sequencer #(
    .LANE_BITS (LB),
    .DCMAX     (DMAX),
    .FCW       (FCW)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Go          (Go),
    .Abort       (Abort),
    .EarlyStop   (EarlyStop),
    .ShiftEn     (ShiftEn),
    .Start       (Start),
    .Enable_Odd  (Enable_Odd),
    .Enable_Even (Enable_Even),
    .Ready       (Ready),
    .MaxHit      (MaxHit),
    .DC          (DC),
    .DCLast      (DCLast),
    .FrameCount  (FrameCount)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_frame = 0; m_done = 0; m_pos = 0;
    m_shift = 0; m_start = 0; m_odd = 0; m_even = 0; m_ready = 0;
    m_maxhit = 0; m_dc = 0; m_last = 0; m_frames = 0;
  endtask

  // Predicts the outputs after the next rising edge given the inputs for it.
  task automatic model_advance(input logic go, input logic ab, input logic es);
    bit dec;
    if (m_frame && ab) begin
      m_frame = 0;
      m_dc = 0;
    end else if (!m_frame) begin
      if (go) begin m_frame = 1; m_pos = 0; m_done = 0; end
    end else if (m_done) begin
      if (go) begin m_pos = 0; m_done = 0; end
      else m_frame = 0;
    end else if (m_pos > LB && (es || (m_pos - LB == DMAX - 1))) begin
      m_done = 1;
      m_maxhit = !es;
      m_last = m_pos - LB;
      m_frames = (m_frames + 1) % FMOD;
    end else begin
      m_pos++;
    end
    m_shift = m_frame && !m_done && (m_pos < LB);
    m_start = m_frame && !m_done && (m_pos == LB);
    dec = m_frame && !m_done && (m_pos > LB);
    if (m_start) m_dc = 0;
    if (dec) m_dc = m_pos - LB;
    m_odd = dec && (m_dc % 2 == 1);
    m_even = dec && (m_dc % 2 == 0);
    m_ready = m_frame && m_done;
  endtask

  task automatic cycle(input logic rst, input logic go, input logic ab, input logic es);
    @(negedge Clock);
    Reset = rst; Go = go; Abort = ab; EarlyStop = es;
    if (rst) model_reset();
    else model_advance(go, ab, es);
  endtask

  // Holds Go high, raises EarlyStop when DC equals stop_dc, returns in the DONE cycle.
  task automatic run_frame(input int stop_dc, output int shifts, output int starts);
    bit seen;
    shifts = 0; starts = 0; seen = 0;
    for (int n = 0; n < 2 * (LB + DMAX) && !seen; n++) begin
      cycle(1'b0, 1'b1, 1'b0, (m_odd || m_even) && (m_dc == stop_dc));
      shifts += int'(ShiftEn);
      starts += int'(Start);
      seen = Ready;
    end
    chk("frame_ready_timeout", seen, 1);
  endtask

  always @(posedge Clock) begin
    #1;
    chk("ShiftEn", ShiftEn, m_shift);
    chk("Start", Start, m_start);
    chk("Enable_Odd", Enable_Odd, m_odd);
    chk("Enable_Even", Enable_Even, m_even);
    chk("Ready", Ready, m_ready);
    chk("MaxHit", MaxHit, m_maxhit);
    chk("DC", DC, m_dc);
    chk("DCLast", DCLast, m_last);
    chk("FrameCount", FrameCount, m_frames);
    chk("odd_even_exclusive", Enable_Odd & Enable_Even, 0);
  end

  initial begin
    int sh, st, n;
    int exp_seq [5];
    bit dec;
    exp_seq = '{1, 2, 3, 0, 1};
    model_reset();
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_FrameCount", FrameCount, 0);
    chk("reset_ShiftEn", ShiftEn, 0);
    chk("reset_DC", DC, 0);

    // Full-length frame hitting the decode limit.
    run_frame(-1, sh, st);
    chk("full_shift_cycles", sh, 200);
    chk("full_start_cycles", st, 1);
    chk("full_DCLast", DCLast, 199);
    chk("full_MaxHit", MaxHit, 1);
    chk("full_FrameCount", FrameCount, 1);
    chk("model_pin_last", m_last, 199);
    @(posedge Clock); #1;
    chk("reload_ShiftEn", ShiftEn, 1);

    run_frame(37, sh, st);
    chk("es37_shift_cycles", sh, 200);
    chk("es37_DCLast", DCLast, 37);
    chk("es37_MaxHit", MaxHit, 0);
    chk("es37_FrameCount", FrameCount, 2);

    run_frame(199, sh, st);
    chk("es199_DCLast", DCLast, 199);
    chk("es199_MaxHit", MaxHit, 0);
    chk("es199_FrameCount", FrameCount, 3);

    // Abort at LOAD bit 120.
    n = 0;
    while (!(m_shift && m_pos == 120) && n < 1000) begin cycle(1'b0, 1'b1, 1'b0, 1'b0); n++; end
    chk("abort_reach_bit120", n < 1000, 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_ShiftEn", ShiftEn, 0);
    chk("abort_Ready", Ready, 0);
    chk("abort_FrameCount", FrameCount, 3);
    chk("abort_DCLast", DCLast, 199);
    run_frame(5, sh, st);
    chk("after_abort_shift_cycles", sh, 200);
    chk("after_abort_FrameCount_wrap", FrameCount, 0);
    chk("after_abort_DCLast", DCLast, 5);

    // Reset pulse mid-DECODE at DC=50.
    n = 0;
    while (!((m_odd || m_even) && m_dc == 50) && n < 1000) begin cycle(1'b0, 1'b1, 1'b0, 1'b0); n++; end
    @(negedge Clock);
    chk("dc_before_reset", DC, 50);
    #1 Reset = 1'b1;
    #1;
    chk("rst_ShiftEn", ShiftEn, 0);
    chk("rst_Start", Start, 0);
    chk("rst_Enable_Odd", Enable_Odd, 0);
    chk("rst_Enable_Even", Enable_Even, 0);
    chk("rst_Ready", Ready, 0);
    chk("rst_MaxHit", MaxHit, 0);
    chk("rst_DC", DC, 0);
    chk("rst_DCLast", DCLast, 0);
    chk("rst_FrameCount", FrameCount, 0);
    model_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    run_frame(10, sh, st);
    chk("post_reset_shift_cycles", sh, 200);
    chk("post_reset_FrameCount", FrameCount, 1);

    // Abort in DONE wins over the reload.
    n = 0;
    while (!m_ready && n < 1000) begin cycle(1'b0, 1'b1, 1'b0, 1'b0); n++; end
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("done_abort_ShiftEn", ShiftEn, 0);

    // FrameCount wrap sequence with a 2-bit counter.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 5; f++) begin
      run_frame($urandom_range(1, 30), sh, st);
      chk("fc_seq", FrameCount, exp_seq[f]);
    end

    // Random traffic: Go dropouts, stray EarlyStop outside DECODE, rare Abort.
    for (int i = 0; i < 8000; i++) begin
      dec = m_odd || m_even;
      if (m_start) es_rate = $urandom_range(0, 4);
      cycle(1'b0, $urandom_range(0, 9) != 0, $urandom_range(0, 799) == 0,
            dec ? ($urandom_range(0, 99) < es_rate) : ($urandom_range(0, 1) == 1));
    end
    @(negedge Clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
